spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

SPI master control stage that sits beside the SPI data register file and drives its second port. On a host "send" command it takes the register file over (`hold_ctrl`), reads each entry as a TX byte, and shifts it out in SPI mode 0, MSB first. It writes each received byte back to the same entry through `wr2`/`in2`. It also holds the host-visible SPI control/status register.

## Interface
- N, 5: register file address msb; entries 0..N, address width N+1.
- DIV, 2: sclk half-period in clk cycles (≥1).

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ctrl_wr  in  1  host write strobe for control register.
- ctrl_wdata  in  32  host write data.
- ctrl_rdata  out  32  control/status readback.
- rd_data  in  32  register file read data (its out_data), combinational on addr2 while hold_ctrl=1.
- hold_ctrl  out  1  register file port select; 1 = this block owns the address.
- addr2  out  N+1  register file entry index.
- wr2  out  1  register file write strobe, one cycle per byte.
- in2  out  8  received byte; register file zero-extends it.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.
- cs_n  out  1  chip select, active low.

## Operation
- Control register fields:
  - [0] send.
  - [1] cs_ctrl: manual CS while idle; cs_n = ~cs_ctrl.
  - [2] all_1s.
  - [3] all_0s.
  - [4] busy (read-only).
  - [15:8] n_tx_end: last index.
  - [23:16] n_rx_end: bytes completed (read-only).
  - Other bits read 0.
- ctrl_wr while busy=0 loads the writable fields. n_tx_end > N is stored as N. ctrl_wr while busy=1 is ignored entirely.
- FSM states: IDLE, LOAD, SHIFT, STORE, DONE.
- IDLE:
  - hold_ctrl=0, wr2=0, sclk=0.
  - If send=1: clear n_rx_end, idx=0, go to LOAD.
- LOAD (1 cycle):
  - hold_ctrl=1, cs_n=0, addr2=idx.
  - Shift register ← 0xFF if all_1s, else 0x00 if all_0s, else rd_data[7:0]. all_1s wins when both are set.
  - mosi = bit 7.
- SHIFT: 8 bits.
  - Each bit is DIV cycles with sclk low, then DIV cycles with sclk high.
  - miso is sampled on the low→high transition.
  - The next bit is presented on mosi at the high→low transition.
  - After the 8th high phase: sclk=0, go to STORE.
- STORE (1 cycle):
  - wr2=1, addr2=idx, in2 = received byte. n_rx_end += 1.
  - If idx == n_tx_end, go to DONE; else idx += 1 and go to LOAD.
- DONE (1 cycle):
  - Clear send. hold_ctrl=0. cs_n returns to ~cs_ctrl next cycle. Go to IDLE.
- hold_ctrl=1 from LOAD through STORE, including every wr2 cycle.
- cs_n stays low continuously between bytes of one send.
- busy=1 in every state except IDLE.

## Timing
- Reset values (all outputs): ctrl register 0, ctrl_rdata 0, hold_ctrl 0, addr2 0, wr2 0, in2 0, sclk 0, mosi 0, cs_n 1; FSM in IDLE.
- ctrl_wr with send=1 at edge k:
  - IDLE samples send=1 in cycle k+1.
  - LOAD occupies cycle k+2 (hold_ctrl and cs_n asserted).
- Per byte: 1 (LOAD) + 16·DIV (SHIFT) + 1 (STORE) cycles.
- Whole send: (n_tx_end+1)·(16·DIV+2) + 1 (DONE) cycles from LOAD entry to IDLE.
- mosi bit 7 is valid DIV cycles before the first sclk rise.
- Reset mid-operation: all outputs return to reset values at the next edge. No further wr2; partial byte discarded.

## Test plan
- Reset: assert rst 2 cycles mid-idle → all outputs at reset values, ctrl_rdata=0.
- Single byte (DIV=2):
  - Stimulus: entry 0 = 0xA5, miso looped to mosi, write ctrl 0x00000001.
  - mosi bits 1,0,1,0,0,1,0,1.
  - 8 sclk pulses, each 2 cycles high and 2 low.
  - One wr2 with addr2=0, in2=0xA5.
  - ctrl_rdata = 0x00010000 after DONE.
  - Busy for 35 cycles.
- Three bytes:
  - Stimulus: entries 0..2 = 0x11,0x22,0x33; slave model returns 0xC3; write ctrl 0x00000201.
  - Entries 0..2 become 0x000000C3.
  - cs_n low continuously; wr2 addr2 sequence 0,1,2; n_rx_end=3.
- Constant TX:
  - ctrl 0x0000000D (all_1s and all_0s set) → mosi 1 for all 8 bits.
  - ctrl 0x00000009 → mosi 0 for all 8 bits.
- Clipping and ignore-while-busy:
  - Write n_tx_end=9 (ctrl 0x00000901) → 6 bytes sent (idx 0..5), n_rx_end=6.
  - ctrl_wr 0x00000000 issued mid-send has no effect.
- Abort: rst after 3 sclk pulses → next cycle cs_n=1, hold_ctrl=0, sclk=0; no wr2 observed.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - host, register-file and SPI pin bundle for spi_master_ctrl
interface spi_master_ctrl_if #(
   parameter int N = 5
) ();
   logic          ctrl_wr;
   logic [31:0]   ctrl_wdata;
   logic [31:0]   ctrl_rdata;
   logic [31:0]   rd_data;
   logic          hold_ctrl;
   logic [N:0]    addr2;
   logic          wr2;
   logic [7:0]    in2;
   logic          sclk;
   logic          mosi;
   logic          miso;
   logic          cs_n;

   modport master (
      input  ctrl_wr, ctrl_wdata, rd_data, miso,
      output ctrl_rdata, hold_ctrl, addr2, wr2, in2, sclk, mosi, cs_n
   );

   modport slave (
      output ctrl_wr, ctrl_wdata, rd_data, miso,
      input  ctrl_rdata, hold_ctrl, addr2, wr2, in2, sclk, mosi, cs_n
   );
endinterface

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master that streams register-file entries out and writes replies back
module spi_master_ctrl #(
   parameter int N   = 5,
   parameter int DIV = 2
) (
   input  logic              clk,
   input  logic              rst,
   spi_master_ctrl_if.master bus
);
   localparam int          CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [7:0]  NMAX = 8'(N);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          send_q, send_d;
   logic          cs_ctrl_q, cs_ctrl_d;
   logic          all1_q, all1_d;
   logic          all0_q, all0_d;
   logic [7:0]    n_tx_end_q, n_tx_end_d;
   logic [7:0]    n_rx_end_q, n_rx_end_d;
   logic [N:0]    idx_q, idx_d;
   logic [7:0]    tx_q, tx_d;
   logic [7:0]    rx_q, rx_d;
   logic          sclk_q, sclk_d;
   logic [CW-1:0] div_q, div_d;
   logic [2:0]    bit_q, bit_d;
   logic          busy;
   logic          unused_bits;

   assign busy        = (state_q != S_IDLE);
   assign unused_bits = ^{bus.ctrl_wdata[31:24], bus.ctrl_wdata[7:4], bus.rd_data[31:8]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         send_q     <= 1'b0;
         cs_ctrl_q  <= 1'b0;
         all1_q     <= 1'b0;
         all0_q     <= 1'b0;
         n_tx_end_q <= 8'd0;
         n_rx_end_q <= 8'd0;
         idx_q      <= '0;
         tx_q       <= 8'd0;
         rx_q       <= 8'd0;
         sclk_q     <= 1'b0;
         div_q      <= '0;
         bit_q      <= 3'd0;
      end else begin
         state_q    <= state_d;
         send_q     <= send_d;
         cs_ctrl_q  <= cs_ctrl_d;
         all1_q     <= all1_d;
         all0_q     <= all0_d;
         n_tx_end_q <= n_tx_end_d;
         n_rx_end_q <= n_rx_end_d;
         idx_q      <= idx_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         sclk_q     <= sclk_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      send_d     = send_q;
      cs_ctrl_d  = cs_ctrl_q;
      all1_d     = all1_q;
      all0_d     = all0_q;
      n_tx_end_d = n_tx_end_q;
      n_rx_end_d = n_rx_end_q;
      idx_d      = idx_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      sclk_d     = sclk_q;
      div_d      = div_q;
      bit_d      = bit_q;

      // Host writes land only while idle; a transfer in flight is never disturbed.
      if (bus.ctrl_wr && !busy) begin
         send_d     = bus.ctrl_wdata[0];
         cs_ctrl_d  = bus.ctrl_wdata[1];
         all1_d     = bus.ctrl_wdata[2];
         all0_d     = bus.ctrl_wdata[3];
         n_tx_end_d = (bus.ctrl_wdata[15:8] > NMAX) ? NMAX : bus.ctrl_wdata[15:8];
      end

      unique case (state_q)
         S_IDLE: begin
            if (send_q) begin
               n_rx_end_d = 8'd0;
               idx_d      = '0;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            tx_d    = all1_q ? 8'hFF : (all0_q ? 8'h00 : bus.rd_data[7:0]);
            div_d   = '0;
            bit_d   = 3'd0;
            sclk_d  = 1'b0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (div_q == CW'(DIV - 1)) begin
               div_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[6:0], bus.miso};
               end else begin
                  sclk_d = 1'b0;
                  tx_d   = {tx_q[6:0], 1'b0};
                  if (bit_q == 3'd7) begin
                     state_d = S_STORE;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end
            end else begin
               div_d = div_q + CW'(1);
            end
         end
         S_STORE: begin
            n_rx_end_d = n_rx_end_q + 8'd1;
            if (idx_q == n_tx_end_q[N:0]) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
            send_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.hold_ctrl  = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_STORE);
   assign bus.wr2        = (state_q == S_STORE);
   assign bus.addr2      = idx_q;
   assign bus.in2        = rx_q;
   assign bus.sclk       = sclk_q;
   assign bus.mosi       = tx_q[7];
   // CS stays asserted through DONE so it only releases after the whole burst.
   assign bus.cs_n       = (state_q == S_IDLE) ? ~cs_ctrl_q : 1'b0;
   assign bus.ctrl_rdata = {8'd0, n_rx_end_q, n_tx_end_q, 3'd0, busy, all0_q, all1_q, cs_ctrl_q, send_q};
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;
   localparam int N   = 5;
   localparam int DIV = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_master_ctrl_if #(.N(N)) bus ();

   spi_master_ctrl #(.N(N), .DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int total = 0;
   int bad   = 0;

   // Register file and SPI slave models.
   logic [31:0] rf [0:63];
   logic        loop_en = 1'b1;
   logic [7:0]  sbyte   = 8'h00;
   logic [2:0]  scnt    = 3'd0;
   logic        sclk_prev = 1'b0;

   assign bus.rd_data = rf[bus.addr2];
   assign bus.miso    = loop_en ? bus.mosi : sbyte[3'd7 - scnt];

   always @(posedge clk) begin
      if (bus.wr2 && bus.hold_ctrl) rf[bus.addr2] <= {24'd0, bus.in2};
      if (!bus.hold_ctrl || bus.wr2) scnt <= 3'd0;
      else if (bus.sclk && !sclk_prev) scnt <= scnt + 3'd1;
      sclk_prev <= bus.sclk;
   end

   // Passive monitor sampled on the falling edge.
   logic       mon_rst = 1'b0;
   int         wr_addr_q[$];
   logic [7:0] wr_data_q[$];
   logic       mosi_q[$];
   int         hi_runs[$];
   int         hi_run = 0;
   int         rises = 0;
   logic       cs_glitch = 1'b0;
   logic       mon_prev = 1'b0;

   always @(negedge clk) begin
      if (mon_rst) begin
         wr_addr_q.delete();
         wr_data_q.delete();
         mosi_q.delete();
         hi_runs.delete();
         hi_run    = 0;
         rises     = 0;
         cs_glitch = 1'b0;
      end else begin
         if (bus.sclk && !mon_prev) begin
            rises++;
            mosi_q.push_back(bus.mosi);
         end
         if (bus.sclk) hi_run++;
         else if (mon_prev) begin
            hi_runs.push_back(hi_run);
            hi_run = 0;
         end
         if (bus.wr2) begin
            wr_addr_q.push_back(int'(bus.addr2));
            wr_data_q.push_back(bus.in2);
         end
         if (bus.hold_ctrl && bus.cs_n) cs_glitch = 1'b1;
      end
      mon_prev = bus.sclk;
   end

   task automatic mon_clear();
      mon_rst = 1'b1;
      @(negedge clk);
      #1 mon_rst = 1'b0;
   endtask

   task automatic write_ctrl(input logic [31:0] d);
      bus.ctrl_wdata = d;
      bus.ctrl_wr    = 1'b1;
      @(posedge clk);
      #1 bus.ctrl_wr = 1'b0;
      @(negedge clk);
   endtask

   // Waits for a started send to finish; reports busy length and whether LOAD came one cycle after idle.
   task automatic run_send(output int busy_cycles, output logic load_ok);
      int n;
      busy_cycles = 0;
      load_ok     = 1'b0;
      for (n = 0; n < 4000; n++) begin
         @(negedge clk);
         if (bus.ctrl_rdata[4]) begin
            if (busy_cycles == 0)
               load_ok = (n == 0) && bus.hold_ctrl && !bus.cs_n;
            busy_cycles++;
         end else if (busy_cycles > 0) begin
            break;
         end
      end
      total++;
      if (n >= 4000) begin
         $display("FAIL send_timeout: busy=%0d required idle within 4000 cycles", busy_cycles);
         bad++;
      end
   endtask

   function automatic logic [7:0] mosi_byte(input int b);
      logic [7:0] v = 8'h00;
      for (int i = 0; i < 8; i++)
         v = {v[6:0], (mosi_q.size() > b*8+i) ? mosi_q[b*8+i] : 1'bx};
      return v;
   endfunction

   task automatic test_reset();
      write_ctrl(32'h0000_0002);
      total++;
      if (bus.cs_n !== 1'b0 || bus.ctrl_rdata !== 32'h2) begin
         $display("FAIL pre_reset_cs: cs_n=%b rdata=%h required cs_n=0 rdata=00000002", bus.cs_n, bus.ctrl_rdata);
         bad++;
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      total++;
      if (bus.ctrl_rdata !== 32'h0) begin
         $display("FAIL reset_rdata: got %h required 00000000", bus.ctrl_rdata); bad++;
      end
      total++;
      if ({bus.hold_ctrl, bus.wr2, bus.sclk, bus.mosi, bus.cs_n} !== 5'b00001) begin
         $display("FAIL reset_ctl: hold,wr2,sclk,mosi,cs_n=%b required 00001",
                  {bus.hold_ctrl, bus.wr2, bus.sclk, bus.mosi, bus.cs_n}); bad++;
      end
      total++;
      if (bus.addr2 !== '0 || bus.in2 !== 8'h00) begin
         $display("FAIL reset_addr_in2: addr2=%0d in2=%h required 0 00", bus.addr2, bus.in2); bad++;
      end
   endtask

   task automatic test_single();
      int bc; logic lok;
      rf[0] = 32'h0000_00A5; loop_en = 1'b1;
      mon_clear();
      write_ctrl(32'h0000_0001);
      run_send(bc, lok);
      total++;
      if (bc != 35) begin $display("FAIL single_busy: got %0d cycles required 35", bc); bad++; end
      total++;
      if (lok !== 1'b1) begin $display("FAIL single_load_timing: got %b required 1", lok); bad++; end
      total++;
      if (mosi_byte(0) !== 8'hA5) begin $display("FAIL single_mosi: got %h required a5", mosi_byte(0)); bad++; end
      total++;
      if (rises != 8 || hi_runs.size() != 8) begin
         $display("FAIL single_pulses: rises=%0d falls=%0d required 8 8", rises, hi_runs.size()); bad++;
      end
      foreach (hi_runs[i]) begin
         total++;
         if (hi_runs[i] != DIV) begin $display("FAIL single_high_len: pulse %0d got %0d required %0d", i, hi_runs[i], DIV); bad++; end
      end
      total++;
      if (wr_addr_q.size() != 1 || wr_addr_q[0] != 0 || wr_data_q[0] !== 8'hA5) begin
         $display("FAIL single_wr2: count=%0d required 1 write of a5 at addr 0", wr_addr_q.size()); bad++;
      end
      total++;
      if (bus.ctrl_rdata !== 32'h0001_0000) begin
         $display("FAIL single_rdata: got %h required 00010000", bus.ctrl_rdata); bad++;
      end
   endtask

   task automatic test_three();
      int bc; logic lok;
      rf[0] = 32'h11; rf[1] = 32'h22; rf[2] = 32'h33;
      loop_en = 1'b0; sbyte = 8'hC3;
      mon_clear();
      write_ctrl(32'h0000_0201);
      run_send(bc, lok);
      total++;
      if (bc != 3*(16*DIV+2)+1) begin $display("FAIL three_busy: got %0d required %0d", bc, 3*(16*DIV+2)+1); bad++; end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rf[i] !== 32'h0000_00C3) begin $display("FAIL three_entry%0d: got %h required 000000c3", i, rf[i]); bad++; end
      end
      total++;
      if (wr_addr_q.size() != 3) begin
         $display("FAIL three_wr_count: got %0d required 3", wr_addr_q.size()); bad++;
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (wr_addr_q[i] != i) begin $display("FAIL three_addr%0d: got %0d required %0d", i, wr_addr_q[i], i); bad++; end
         end
      end
      total++;
      if (cs_glitch !== 1'b0) begin $display("FAIL three_cs_cont: glitch=%b required 0", cs_glitch); bad++; end
      total++;
      if (mosi_byte(1) !== 8'h22) begin $display("FAIL three_mosi1: got %h required 22", mosi_byte(1)); bad++; end
      total++;
      if (bus.ctrl_rdata[23:16] !== 8'd3) begin $display("FAIL three_rx_end: got %0d required 3", bus.ctrl_rdata[23:16]); bad++; end
   endtask

   task automatic test_const();
      int bc; logic lok;
      rf[0] = 32'h5A; loop_en = 1'b1;
      mon_clear();
      write_ctrl(32'h0000_000D);
      run_send(bc, lok);
      total++;
      if (mosi_byte(0) !== 8'hFF) begin $display("FAIL const_ones: got %h required ff", mosi_byte(0)); bad++; end
      total++;
      if (wr_data_q.size() != 1 || wr_data_q[0] !== 8'hFF) begin $display("FAIL const_ones_wr: required one write of ff"); bad++; end
      rf[0] = 32'h5A;
      mon_clear();
      write_ctrl(32'h0000_0009);
      run_send(bc, lok);
      total++;
      if (mosi_byte(0) !== 8'h00) begin $display("FAIL const_zeros: got %h required 00", mosi_byte(0)); bad++; end
      total++;
      if (rf[0] !== 32'h0) begin $display("FAIL const_zeros_rf: got %h required 00000000", rf[0]); bad++; end
   endtask

   task automatic test_clip_busy();
      int bc; int n;
      for (int i = 0; i < 6; i++) rf[i] = 32'(8'h40 + i);
      loop_en = 1'b1;
      mon_clear();
      write_ctrl(32'h0000_0901);
      total++;
      if (bus.ctrl_rdata[15:8] !== 8'd5) begin $display("FAIL clip_tx_end: got %0d required 5", bus.ctrl_rdata[15:8]); bad++; end
      repeat (50) @(negedge clk);
      write_ctrl(32'h0000_0000);
      bc = 0;
      for (n = 0; n < 4000 && bus.ctrl_rdata[4]; n++) @(negedge clk);
      total++;
      if (bus.ctrl_rdata[4] !== 1'b0) begin $display("FAIL clip_timeout: busy stuck required idle"); bad++; end
      total++;
      if (wr_addr_q.size() != 6) begin
         $display("FAIL clip_wr_count: got %0d required 6", wr_addr_q.size()); bad++;
      end else begin
         total++;
         if (wr_addr_q[5] != 5 || wr_data_q[5] !== 8'h45) begin
            $display("FAIL clip_last: addr=%0d data=%h required 5 45", wr_addr_q[5], wr_data_q[5]); bad++;
         end
      end
      total++;
      if (bus.ctrl_rdata !== 32'h0006_0500) begin $display("FAIL clip_rdata: got %h required 00060500", bus.ctrl_rdata); bad++; end
   endtask

   task automatic test_abort();
      int n;
      rf[0] = 32'hF0; loop_en = 1'b1;
      mon_clear();
      write_ctrl(32'h0000_0001);
      for (n = 0; n < 500 && rises < 3; n++) @(negedge clk);
      total++;
      if (rises < 3) begin $display("FAIL abort_wait: rises=%0d required 3", rises); bad++; end
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({bus.cs_n, bus.hold_ctrl, bus.sclk, bus.wr2} !== 4'b1000 || bus.ctrl_rdata !== 32'h0) begin
         $display("FAIL abort_outputs: cs_n,hold,sclk,wr2=%b rdata=%h required 1000 00000000",
                  {bus.cs_n, bus.hold_ctrl, bus.sclk, bus.wr2}, bus.ctrl_rdata); bad++;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      total++;
      if (wr_addr_q.size() != 0 || rf[0] !== 32'hF0) begin
         $display("FAIL abort_no_wr: writes=%0d rf0=%h required 0 000000f0", wr_addr_q.size(), rf[0]); bad++;
      end
   endtask

   initial begin
      bus.ctrl_wr    = 1'b0;
      bus.ctrl_wdata = 32'h0;
      for (int i = 0; i < 64; i++) rf[i] = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_three();
      test_const();
      test_clip_busy();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
